// File: rtl/tile_packer.sv
// Packs content/generated pixel pairs into SIZE-lane tiles for the downstream loss stage.
// Define TILE_PACKER_STALL_CNT_EN to add the stall_count output (HOLD cycles without tile_ready).
module tile_packer #(
    parameter int unsigned SIZE = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_content,
    input  logic [15:0]           in_generated,
    input  logic                  in_last,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic [SIZE-1:0][15:0] content_pixels,
    output logic [SIZE-1:0][15:0] generated_pixels,
    output logic                  tile_last,
    output logic [$clog2(SIZE):0] tile_count
`ifdef TILE_PACKER_STALL_CNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [SIZE-1:0][15:0]   r_content;
    logic [SIZE-1:0][15:0]   r_generated;
    logic [CNT_W-1:0]        r_count;
    logic                    r_last;
    logic                    w_accept;
    logic                    w_close;
    logic                    w_xfer;

    // Next state plus the accept / close / transfer strobes for the datapath
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_close     = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            FILL: begin
                w_accept = in_valid;
                w_close  = in_valid && ((r_idx == IDX_W'(SIZE - 1)) || in_last);
                if (w_close) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_xfer = tile_ready;
                if (tile_ready) begin
                    w_state_nxt = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lane buffers are wiped on transfer so a short tile's unwritten lanes read zero
    always_ff @(posedge clk) begin
        if (reset || w_xfer) begin
            r_idx       <= '0;
            r_content   <= '0;
            r_generated <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
        end else if (w_accept) begin
            r_content[r_idx]   <= in_content;
            r_generated[r_idx] <= in_generated;
            r_idx              <= w_close ? '0 : r_idx + IDX_W'(1);
            if (w_close) begin
                r_count <= CNT_W'(r_idx) + CNT_W'(1);
                r_last  <= in_last;
            end
        end
    end

    assign in_ready         = (r_state == FILL);
    assign tile_valid       = (r_state == HOLD);
    assign content_pixels   = r_content;
    assign generated_pixels = r_generated;
    assign tile_count       = r_count;
    assign tile_last        = r_last;

`ifdef TILE_PACKER_STALL_CNT_EN
    logic [31:0] r_stall;

    // Saturating count of cycles a presented tile waits on the consumer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if ((r_state == HOLD) && !tile_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_count = r_stall;
`endif

endmodule

// File: tb/tb_tile_packer.sv
// Bench for tile_packer: table-driven directed tiles, reset corner sequences and a random
// stream checked by a negedge scoreboard of accepted pairs and transferred tiles.
`timescale 1ns/1ps
module tb_tile_packer;

    localparam int unsigned SIZE  = 64;
    localparam int unsigned CNT_W = $clog2(SIZE) + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [15:0]           in_content;
    logic [15:0]           in_generated;
    logic                  in_last;
    logic                  tile_valid;
    logic                  tile_ready;
    logic [SIZE-1:0][15:0] content_pixels;
    logic [SIZE-1:0][15:0] generated_pixels;
    logic                  tile_last;
    logic [CNT_W-1:0]      tile_count;
`ifdef TILE_PACKER_STALL_CNT_EN
    logic [31:0]           stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    tile_packer #(.SIZE(SIZE)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_content       (in_content),
        .in_generated     (in_generated),
        .in_last          (in_last),
        .tile_valid       (tile_valid),
        .tile_ready       (tile_ready),
        .content_pixels   (content_pixels),
        .generated_pixels (generated_pixels),
        .tile_last        (tile_last),
        .tile_count       (tile_count)
`ifdef TILE_PACKER_STALL_CNT_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_stall();
`ifdef TILE_PACKER_STALL_CNT_EN
        check("stall_count", stall_count, 32'(exp_stall));
`endif
    endtask

    // Scoreboard: pairs accepted since the last tile, predicted HOLD state, tile log
    typedef struct packed {
        logic [15:0] c;
        logic [15:0] g;
        logic        last;
    } pair_t;

    pair_t sb_q[$];
    bit    m_hold = 1'b0;
    bit    mon_en = 1'b0;
    bit    log_en = 1'b0;
    int    tile_log[$];
    bit    last_log[$];
    int    pairs_seen = 0;

    task automatic check_tile();
        int first_bad = -1;
        logic [15:0] ec, eg;
        for (int i = 0; i < int'(SIZE); i++) begin
            ec = (i < sb_q.size()) ? sb_q[i].c : 16'h0;
            eg = (i < sb_q.size()) ? sb_q[i].g : 16'h0;
            if (first_bad < 0 && (content_pixels[i] !== ec || generated_pixels[i] !== eg)) begin
                first_bad = i;
            end
        end
        check("mon_tile_count", 32'(tile_count), 32'(sb_q.size()));
        check("mon_tile_last", 32'(tile_last), 32'(sb_q[sb_q.size()-1].last));
        check("mon_tile_first_bad_lane", 32'(first_bad), 32'hFFFF_FFFF);
        pairs_seen += sb_q.size();
        if (log_en) begin
            tile_log.push_back(int'(tile_count));
            last_log.push_back(tile_last);
        end
        sb_q.delete();
    endtask

    always @(negedge clk) begin
        pair_t p;
        if (mon_en) begin
            if (reset) begin
                sb_q.delete();
                m_hold = 1'b0;
            end else begin
                check("mon_tile_valid", 32'(tile_valid), 32'(m_hold));
                check("mon_in_ready", 32'(in_ready), 32'(!m_hold));
                if (m_hold) begin
                    if (tile_ready) begin
                        check_tile();
                        m_hold = 1'b0;
                    end
                end else if (in_valid) begin
                    p.c    = in_content;
                    p.g    = in_generated;
                    p.last = in_last;
                    sb_q.push_back(p);
                    if (sb_q.size() == int'(SIZE) || in_last) m_hold = 1'b1;
                end
            end
        end
    end

    typedef struct {
        int          n;
        bit          has_last;
        int          stall;
        logic [15:0] base;
        int          probe;
        logic [15:0] exp_c;
        logic [15:0] exp_g;
        int          exp_count;
        bit          exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_tile_valid"}, 32'(tile_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_lanes_zero"}, 32'(content_pixels == '0 && generated_pixels == '0), 32'd1);
        check({tag, "_count"}, 32'(tile_count), 32'd0);
        check({tag, "_last"}, 32'(tile_last), 32'd0);
    endtask

    // Stream one tile, hold it for v.stall cycles, then a one-pair marker tile follows
    task automatic run_vec(input vec_t v, input int id);
        logic [15:0] marker;
        marker     = 16'h0700 + 16'(id);
        tile_ready = (v.stall == 0);
        for (int k = 0; k < v.n; k++) begin
            in_valid     = 1'b1;
            in_content   = 16'(v.base + 16'(k));
            in_generated = 16'(2 * (v.base + 16'(k)));
            in_last      = v.has_last && (k == v.n - 1);
            step();
        end
        in_content   = marker;
        in_generated = 16'(marker << 1);
        in_last      = 1'b1;
        check("vec_tile_valid", 32'(tile_valid), 32'd1);
        check("vec_in_ready", 32'(in_ready), 32'd0);
        check("vec_tile_count", 32'(tile_count), 32'(v.exp_count));
        check("vec_tile_last", 32'(tile_last), 32'(v.exp_last));
        check("vec_probe_content", 32'(content_pixels[v.probe]), 32'(v.exp_c));
        check("vec_probe_generated", 32'(generated_pixels[v.probe]), 32'(v.exp_g));
        if (v.exp_count < int'(SIZE)) begin
            check("vec_pad_zero", 32'({content_pixels[v.exp_count], generated_pixels[v.exp_count]}), 32'd0);
        end
        for (int s = 0; s < v.stall; s++) begin
            step();
            check("stall_tile_valid", 32'(tile_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_count_stable", 32'(tile_count), 32'(v.exp_count));
            check("stall_probe_stable", 32'(content_pixels[v.probe]), 32'(v.exp_c));
        end
        exp_stall += v.stall;
        tile_ready = 1'b1;
        step();
        check_cleared("xfer");
        check_stall();
        step();
        check("marker_tile_valid", 32'(tile_valid), 32'd1);
        check("marker_count", 32'(tile_count), 32'd1);
        check("marker_last", 32'(tile_last), 32'd1);
        check("marker_lane0", 32'({content_pixels[0], generated_pixels[0]}), 32'({marker, 16'(marker << 1)}));
        check("marker_lane1_zero", 32'({content_pixels[1], generated_pixels[1]}), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        check("marker_done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t rv;
        int   k;
        int   cyc;
        int   w;
        int   seen0;
        bit   acc;

        vecs[0] = '{64, 1'b0, 0, 16'h0000,  5, 16'd5,    16'd10,   64, 1'b0};
        vecs[1] = '{10, 1'b1, 0, 16'h0000, 10, 16'd0,    16'd0,    10, 1'b1};
        vecs[2] = '{64, 1'b1, 0, 16'h0000, 63, 16'd63,   16'd126,  64, 1'b1};
        vecs[3] = '{64, 1'b0, 7, 16'h0040,  0, 16'h0040, 16'h0080, 64, 1'b0};
        vecs[4] = '{ 1, 1'b1, 3, 16'h1234,  0, 16'h1234, 16'h2468,  1, 1'b1};
        vecs[5] = '{37, 1'b1, 0, 16'h7F00, 36, 16'h7F24, 16'hFE48, 37, 1'b1};
        vecs[6] = '{64, 1'b0, 0, 16'hFFC0, 63, 16'hFFFF, 16'hFFFE, 64, 1'b0};

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_content   = '0;
        in_generated = '0;
        in_last      = 1'b0;
        tile_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        check_cleared("reset");
        check_stall();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset after 30 accepted pairs, with a pair offered on the reset cycle
        tile_ready = 1'b1;
        for (int j = 0; j < 30; j++) begin
            in_valid     = 1'b1;
            in_content   = 16'(16'h0500 + 16'(j));
            in_generated = 16'(16'h0A00 + 16'(j));
            in_last      = 1'b0;
            step();
        end
        check("midfill_no_tile", 32'(tile_valid), 32'd0);
        reset      = 1'b1;
        in_content = 16'h9999;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_stall = 0;
        check_cleared("midfill_reset");
        check_stall();
        rv = '{64, 1'b0, 0, 16'h0200, 0, 16'h0200, 16'h0400, 64, 1'b0};
        run_vec(rv, 7);

        // Reset while a tile is presented and tile_ready is asserted together
        tile_ready = 1'b0;
        for (int j = 0; j < 64; j++) begin
            in_valid     = 1'b1;
            in_content   = 16'(j);
            in_generated = 16'(16'h4000 + 16'(j));
            in_last      = 1'b0;
            step();
        end
        check("hold_before_reset", 32'(tile_valid), 32'd1);
        in_valid   = 1'b0;
        reset      = 1'b1;
        tile_ready = 1'b1;
        step();
        reset = 1'b0;
        check_cleared("midhold_reset");
        check_stall();

        // Random handshakes over 1000 pairs with in_last on every 100th pair
        seen0  = pairs_seen;
        log_en = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 1000 && cyc < 20000) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_content   = 16'(k);
            in_generated = 16'h8000 ^ 16'(k);
            in_last      = ((k % 100) == 99);
            tile_ready   = 1'($urandom_range(0, 1));
            acc          = in_valid && in_ready;
            step();
            if (acc) k++;
            cyc++;
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        tile_ready = 1'b1;
        w = 0;
        while ((tile_valid || sb_q.size() != 0) && w < 200) begin
            step();
            w++;
        end
        step();
        check("rand_pairs_sent", 32'(k), 32'd1000);
        check("rand_drained", 32'(w < 200), 32'd1);
        check("rand_pairs_seen", 32'(pairs_seen - seen0), 32'd1000);
        check("rand_tile_total", 32'(tile_log.size()), 32'd20);
        for (int t = 0; t < tile_log.size(); t++) begin
            check("rand_tile_count", 32'(tile_log[t]), (t % 2 == 1) ? 32'd36 : 32'd64);
            check("rand_tile_last", 32'(last_log[t]), 32'(t % 2 == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
